// File: rtl/detector_secuencias.sv
// Serial bit-sequence detector: Moore FSM whose transitions follow the KMP failure rule of PATTERN.
// det is decoded from the registered state only, so overlapping matches each give one pulse.
module detector_secuencias #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic det
);

  localparam int unsigned SW = $clog2(LEN + 1);

  // Sk = length of the longest received suffix that is also a prefix of PATTERN.
  typedef enum logic [SW-1:0] {
    S0   = SW'(0),
    SLen = SW'(LEN)
  } state_e;

  // Next state from Sk on bit b: longest suffix of (prefix_k, b) that is a PATTERN prefix.
  function automatic int unsigned kmp_next(input int unsigned k, input logic b);
    int unsigned    res;
    int unsigned    idx;
    logic           ok;
    logic           sb;
    logic [LEN-1:0] sh_s;
    logic [LEN-1:0] sh_p;
    res = 0;
    for (int unsigned j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < j; i++) begin
          idx = k + 1 - j + i;
          if (idx == k) begin
            sb = b;
          end else begin
            sh_s = PATTERN >> (LEN - 1 - idx);
            sb   = sh_s[0];
          end
          sh_p = PATTERN >> (LEN - 1 - i);
          if (sb != sh_p[0]) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  logic [SW-1:0] w_nxt0 [LEN+1];
  logic [SW-1:0] w_nxt1 [LEN+1];

  for (genvar k = 0; k <= int'(LEN); k++) begin : g_tbl
    assign w_nxt0[k] = SW'(kmp_next(k, 1'b0));
    assign w_nxt1[k] = SW'(kmp_next(k, 1'b1));
  end

  state_e r_state = S0;
  state_e w_state_next;

  // Encodings above SLen match no table row and fall back to S0.
  always_comb begin
    w_state_next = S0;
    for (int k = 0; k <= int'(LEN); k++) begin
      if (r_state == SW'(k)) w_state_next = state_e'(din ? w_nxt1[k] : w_nxt0[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign det = (r_state == SLen);

endmodule

// File: tb/tb_detector_secuencias.sv
// Bench for detector_secuencias: shift-register reference model feeds a scoreboard queue,
// and each scenario task also checks hand-derived pulse positions and key states.
module tb_detector_secuencias;

  localparam int       LEN     = 4;
  localparam logic [3:0] PATTERN = 4'b1101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic det;

  int checks = 0;
  int errors = 0;

  bit             sb_q[$];
  logic [LEN-1:0] m_hist = '0;
  int             m_cnt  = 0;

  detector_secuencias #(
    .LEN    (LEN),
    .PATTERN(PATTERN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .det(det)
  );

  always #5 clk = ~clk;

  // Scoreboard: each edge's expected det was pushed when its stimulus was driven.
  always @(posedge clk) begin
    bit e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (det !== e) begin
        errors++;
        $display("FAIL scoreboard_det t=%0t: got %b expected %b", $time, det, e);
      end
    end
  end

  // Drive one bit (with rst) on the falling edge, predict det, return det seen after the edge.
  task automatic drive(input logic b, input logic r, output logic obs);
    @(negedge clk);
    din = b;
    rst = r;
    if (r) begin
      m_hist = '0;
      m_cnt  = 0;
      sb_q.push_back(1'b0);
    end else begin
      m_hist = {m_hist[LEN-2:0], b};
      if (m_cnt < LEN) m_cnt++;
      sb_q.push_back((m_cnt >= LEN) && (m_hist == PATTERN));
    end
    @(posedge clk);
    #2;
    obs = det;
  endtask

  // Bits are given MSB-first; got collects det after each bit, MSB-first.
  task automatic stream(input logic [31:0] bits, input int n, output logic [31:0] got);
    logic o;
    got = '0;
    for (int i = 0; i < n; i++) begin
      drive(bits[n-1-i], 1'b0, o);
      got = {got[30:0], o};
    end
  endtask

  task automatic do_reset();
    logic o;
    drive(1'b0, 1'b1, o);
  endtask

  task automatic test_reset();
    logic o;
    #1;
    checks++;
    if (det !== 1'b0) begin
      errors++;
      $display("FAIL powerup_det: got %b expected 0", det);
    end
    drive(1'b1, 1'b1, o);
    drive(1'b1, 1'b1, o);
    checks++;
    if (int'(dut.r_state) !== 0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state %0d det %b expected state 0 det 0",
               int'(dut.r_state), o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    do_reset();
    stream(32'b00110101, 8, got);
    checks++;
    if (got !== 32'b00000100) begin
      errors++;
      $display("FAIL basic_match: got pulses %b expected %b", got[7:0], 8'b00000100);
    end
  endtask

  task automatic test_reset_mid();
    logic o;
    logic [31:0] got;
    drive(1'b1, 1'b1, o);
    checks++;
    if (int'(dut.r_state) !== 0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got state %0d det %b expected state 0 det 0",
               int'(dut.r_state), o);
    end
    stream(32'b110, 3, got);
    drive(1'b1, 1'b1, o);
    checks++;
    if (int'(dut.r_state) !== 0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_s3: got state %0d det %b expected state 0 det 0",
               int'(dut.r_state), o);
    end
  endtask

  task automatic test_post_reset();
    logic [31:0] got;
    stream(32'b011010100100100, 15, got);
    checks++;
    if (got !== 32'b000010000000000) begin
      errors++;
      $display("FAIL post_reset_stream: got pulses %b expected %b", got[14:0],
               15'b000010000000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    stream(32'b1101101, 7, got);
    checks++;
    if (got !== 32'b0001001) begin
      errors++;
      $display("FAIL overlap: got pulses %b expected %b", got[6:0], 7'b0001001);
    end
  endtask

  task automatic test_near_miss();
    logic        o;
    logic [10:0] bits;
    logic [31:0] got;
    bits = 11'b11100101010;
    got  = '0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(bits[10-i], 1'b0, o);
      got = {got[30:0], o};
      if (i == 1 || i == 2) begin
        checks++;
        if (int'(dut.r_state) !== 2) begin
          errors++;
          $display("FAIL ones_hold_s2 bit%0d: got state %0d expected 2", i + 1,
                   int'(dut.r_state));
        end
      end
      if (i == 4) begin
        checks++;
        if (int'(dut.r_state) !== 0) begin
          errors++;
          $display("FAIL s3_zero_to_s0: got state %0d expected 0", int'(dut.r_state));
        end
      end
    end
    checks++;
    if (got !== 32'b0) begin
      errors++;
      $display("FAIL near_miss: got pulses %b expected none", got[10:0]);
    end
  endtask

  task automatic test_reset_vs_completion();
    logic o;
    logic [31:0] got;
    do_reset();
    stream(32'b110, 3, got);
    drive(1'b1, 1'b1, o);
    checks++;
    if (int'(dut.r_state) !== 0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_completion: got state %0d det %b expected state 0 det 0",
               int'(dut.r_state), o);
    end
    drive(1'b0, 1'b0, o);
    checks++;
    if (o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_completion: got det %b expected 0", o);
    end
  endtask

  task automatic test_random();
    logic o;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_post_reset();
    test_back_to_back();
    test_near_miss();
    test_reset_vs_completion();
    test_random();
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
